// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int PRESCALE_8         = 8;
  localparam int PRESCALE_16        = 16;
  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Serial line, checker results and sequencer outputs of the receive path.
interface uart_rx_frame_ctrl_if #(parameter int PRESCALE_W = 5);

  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [3:0]            edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  dat_samp_en;
  logic                  deser_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
  logic                  frame_err;

  modport master (
    input  RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en,
           strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err
  );

  modport slave (
    output RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en,
           strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err
  );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter; edge_cnt wraps at ps_q-1
// and each wrap advances bit_cnt.
module uart_rx_edge_bit_cnt #(
  parameter int PRESCALE_W = 5
) (
  input  logic                  CLK_DESERIALIZER,
  input  logic                  RST_DESERIALIZER,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] ps_q,
  output logic [3:0]            edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  last_edge
);

  assign last_edge = (PRESCALE_W'(edge_cnt) == (ps_q - PRESCALE_W'(1)));

  always_ff @(posedge CLK_DESERIALIZER or negedge RST_DESERIALIZER) begin
    if (!RST_DESERIALIZER) begin
      edge_cnt <= 4'd0;
      bit_cnt  <= 4'd0;
    end else if (clr) begin
      edge_cnt <= 4'd0;
      bit_cnt  <= 4'd0;
    end else if (en) begin
      if (last_edge) begin
        edge_cnt <= 4'd0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level sequencer for the UART receiver: start detection, counter
// control, sampler/deserializer/checker enables and frame result pulses.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PRESCALE_W = 5
) (
  input  logic                 CLK_DESERIALIZER,
  input  logic                 RST_DESERIALIZER,
  uart_rx_frame_ctrl_if.master bus
);

  state_t                state, next_state;
  logic [1:0]            rst_sync_q;
  logic                  rst_sync;
  logic [PRESCALE_W-1:0] ps_q;
  logic                  ps_legal;
  logic                  latch_ps;
  logic                  last_edge;
  logic                  cnt_clr;
  logic                  strt_chk, par_chk, stp_chk;
  logic                  dv_next, fe_next;
  logic                  data_valid_q, frame_err_q;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge CLK_DESERIALIZER or negedge RST_DESERIALIZER) begin
    if (!RST_DESERIALIZER) rst_sync_q <= 2'b00;
    else                   rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync = rst_sync_q[1];

  assign ps_legal = (bus.Prescale == PRESCALE_W'(PRESCALE_8)) ||
                    (bus.Prescale == PRESCALE_W'(PRESCALE_16));

  // Counters restart whenever the frame ends, including a back-to-back start.
  assign cnt_clr = (next_state == IDLE) || ((state == STOP) && last_edge);

  uart_rx_edge_bit_cnt #(.PRESCALE_W(PRESCALE_W)) u_cnt (
    .CLK_DESERIALIZER (CLK_DESERIALIZER),
    .RST_DESERIALIZER (rst_sync),
    .en               (state != IDLE),
    .clr              (cnt_clr),
    .ps_q             (ps_q),
    .edge_cnt         (bus.edge_cnt),
    .bit_cnt          (bus.bit_cnt),
    .last_edge        (last_edge)
  );

  always_comb begin
    next_state = state;
    latch_ps   = 1'b0;
    strt_chk   = 1'b0;
    par_chk    = 1'b0;
    stp_chk    = 1'b0;
    dv_next    = 1'b0;
    fe_next    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.RX_IN && ps_legal) begin
          next_state = START;
          latch_ps   = 1'b1;
        end
      end
      START: begin
        if (last_edge) begin
          strt_chk = 1'b1;
          if (bus.strt_glitch) begin
            next_state = IDLE;
            fe_next    = 1'b1;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (last_edge && (bus.bit_cnt == 4'(DATA_WIDTH)))
          next_state = bus.PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (last_edge) begin
          par_chk = 1'b1;
          if (bus.par_err) begin
            next_state = IDLE;
            fe_next    = 1'b1;
          end else begin
            next_state = STOP;
          end
        end
      end
      STOP: begin
        if (last_edge) begin
          stp_chk = 1'b1;
          fe_next = bus.stp_err;
          dv_next = !bus.stp_err;
          if (!bus.RX_IN && ps_legal) begin
            next_state = START;
            latch_ps   = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK_DESERIALIZER or negedge rst_sync) begin
    if (!rst_sync) begin
      state        <= IDLE;
      ps_q         <= PRESCALE_W'(PRESCALE_8);
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state        <= next_state;
      data_valid_q <= dv_next;
      frame_err_q  <= fe_next;
      if (latch_ps) ps_q <= bus.Prescale;
    end
  end

  assign bus.dat_samp_en = (state != IDLE);
  assign bus.deser_en    = (state == DATA);
  assign bus.strt_chk_en = strt_chk;
  assign bus.par_chk_en  = par_chk;
  assign bus.stp_chk_en  = stp_chk;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule
